demux_1xn_scheduler: RTL and testbench

Sequencing controller for the 1-to-N demultiplexer datapath. Accepts a stream of data words on a valid/ready input, selects an output channel per word (round-robin or directed by a destination field), and presents the word on that channel with a per-channel valid/ready handshake. It sits in front of the demux so that several downstream consumers share one producer without losing or duplicating words.

---
 rtl/demux_pkg.sv | 11 +
 rtl/rr_pointer.sv | 32 +++
 rtl/demux_1xn_scheduler.sv | 94 +++++++++
 tb/tb_demux_1xn_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared encodings and constants for the 1-to-N demux scheduler and its helpers.
package demux_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam int CNT_W = 16;

endpackage

// File: rtl/rr_pointer.sv
// N-way modulo pointer: steps by one on each enabled cycle, wrapping N-1 -> 0.
module rr_pointer #(
    parameter int N  = 4,
    parameter int DW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv_i,
    output logic [DW-1:0] ptr_o
);

    logic [DW-1:0] ptr_q;
    logic [DW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = (ptr_q == DW'(N - 1)) ? '0 : ptr_q + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/demux_1xn_scheduler.sv
// Single-entry holding stage that routes each accepted word to one of N channels,
// either round-robin or by a destination field, with per-channel valid/ready.
module demux_1xn_scheduler
    import demux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int DW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [DW-1:0]    in_dest,
    output logic [N-1:0]     out_valid,
    output logic [W-1:0]     out_data,
    input  logic [N-1:0]     out_ready,
    output logic             err_dest,
    output logic [CNT_W-1:0] sent_cnt
);

    state_t           state_q, state_d;
    logic [W-1:0]     data_q, data_d;
    logic [DW-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [DW-1:0] rr_ptr;
    logic          deliver;
    logic          accept;
    logic          bad_dest;

    rr_pointer #(.N(N), .DW(DW)) u_rr_pointer (
        .clk   (clk),
        .rst   (rst),
        .adv_i (accept && !mode),
        .ptr_o (rr_ptr)
    );

    // Only the selected channel's ready matters; this is the one input-to-output comb path.
    assign deliver  = (state_q == ST_FULL) && out_ready[sel_q];
    assign in_ready = !rst && ((state_q == ST_EMPTY) || deliver);
    assign accept   = in_valid && in_ready;
    assign bad_dest = mode && (int'(in_dest) >= N);

    // NOTE: every _d starts from its held value, so no branch can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        err_d   = accept && bad_dest;
        if (deliver) begin
            state_d = ST_EMPTY;
            cnt_d   = cnt_q + CNT_W'(1);
        end
        if (accept && !bad_dest) begin
            state_d = ST_FULL;
            data_d  = in_data;
            sel_d   = mode ? in_dest : rr_ptr;
        end
    end

    // NOTE: non-blocking assignments so each register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        out_valid = '0;
        if (state_q == ST_FULL) begin
            out_valid[sel_q] = 1'b1;
        end
    end

    assign out_data = data_q;
    assign err_dest = err_q;
    assign sent_cnt = cnt_q;

endmodule

// File: tb/tb_demux_1xn_scheduler.sv
// Directed bench for demux_1xn_scheduler: a scoreboard tracks every accepted word on the
// N=4 instance, and a second N=3 instance covers out-of-range directed destinations.
module tb_demux_1xn_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        mode, in_valid, in_ready, err_dest;
    logic [7:0]  in_data, out_data;
    logic [1:0]  in_dest;
    logic [3:0]  out_valid, out_ready;
    logic [15:0] sent_cnt;

    logic        mode3, in_valid3, in_ready3, err_dest3;
    logic [7:0]  in_data3, out_data3;
    logic [1:0]  in_dest3;
    logic [2:0]  out_valid3, out_ready3;
    logic [15:0] sent_cnt3;

    demux_1xn_scheduler #(.N(4), .W(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dest(in_dest), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .err_dest(err_dest), .sent_cnt(sent_cnt)
    );

    demux_1xn_scheduler #(.N(3), .W(8)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .in_dest(in_dest3), .out_valid(out_valid3), .out_data(out_data3),
        .out_ready(out_ready3), .err_dest(err_dest3), .sent_cnt(sent_cnt3)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] chan;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    logic [1:0] tb_rr = 2'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Scoreboard: a delivery (seen before the edge that performs it) pops the oldest
    // expected word; an accepted input pushes the channel the bench predicts for it.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
            tb_rr = 2'd0;
        end else begin
            check("onehot", 32'($onehot0(out_valid)), 32'd1);
            if ((out_valid & out_ready) != 4'd0) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_delivery", 32'(out_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("dlv_chan", 32'(out_valid), 32'd1 << e.chan);
                    check("dlv_data", 32'(out_data), 32'(e.data));
                end
            end
            if (in_valid && in_ready) begin
                e.chan = mode ? in_dest : tb_rr;
                e.data = in_data;
                sb_q.push_back(e);
                if (!mode) tb_rr = tb_rr + 2'd1;
            end
        end
    end

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        sample();
        check("rst_in_ready_during", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        sample();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_sent_cnt", 32'(sent_cnt), 32'd0);
        check("rst_err_dest", 32'(err_dest), 32'd0);
        check("rst_in_ready_after", 32'(in_ready), 32'd1);
        tick();
    endtask

    logic [7:0] t1_data[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int         t1_ov[5]   = '{1, 2, 4, 8, 1};
    logic [1:0] t3_dest[3] = '{2'd3, 2'd3, 2'd0};
    logic [7:0] t3_data[3] = '{8'hA0, 8'hA1, 8'hA2};

    initial begin
        mode       = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_dest    = 2'd0;
        out_ready  = 4'h0;
        mode3      = 1'b0;
        in_valid3  = 1'b0;
        in_data3   = 8'h00;
        in_dest3   = 2'd0;
        out_ready3 = 3'b000;
        rst        = 1'b1;
        tick();
        do_reset();

        // N=3 instance: out-of-range destination is dropped with a one-cycle error pulse.
        mode3 = 1'b1; out_ready3 = 3'b111; in_valid3 = 1'b1; in_dest3 = 2'd3; in_data3 = 8'hEE;
        sample();
        check("t4_in_ready", 32'(in_ready3), 32'd1);
        check("t4_err_before", 32'(err_dest3), 32'd0);
        tick();
        in_valid3 = 1'b0;
        sample();
        check("t4_err_pulse", 32'(err_dest3), 32'd1);
        check("t4_no_valid", 32'(out_valid3), 32'd0);
        check("t4_cnt_same", 32'(sent_cnt3), 32'd0);
        tick();
        sample();
        check("t4_err_cleared", 32'(err_dest3), 32'd0);
        check("t4_no_valid2", 32'(out_valid3), 32'd0);
        tick();
        in_valid3 = 1'b1; in_dest3 = 2'd2; in_data3 = 8'h5A;
        sample();
        tick();
        in_valid3 = 1'b0;
        sample();
        check("t4_good_valid", 32'(out_valid3), 32'h4);
        check("t4_good_data", 32'(out_data3), 32'h5A);
        tick();
        sample();
        check("t4_good_cnt", 32'(sent_cnt3), 32'd1);
        tick();

        // Round-robin, all consumers ready: one word per cycle across channels 0..3,0.
        mode = 1'b0; out_ready = 4'hF;
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) begin
                in_valid = 1'b1;
                in_data  = t1_data[i];
            end else begin
                in_valid = 1'b0;
            end
            sample();
            if (i < 5) check("t1_in_ready", 32'(in_ready), 32'd1);
            if (i > 0) begin
                check("t1_out_valid", 32'(out_valid), 32'(t1_ov[i-1]));
                check("t1_out_data", 32'(out_data), 32'(t1_data[i-1]));
            end
            tick();
        end
        sample();
        check("t1_sent_cnt", 32'(sent_cnt), 32'd5);
        check("t1_idle", 32'(out_valid), 32'd0);
        tick();

        // Directed words 3,3,0 leave the round-robin pointer at 0.
        do_reset();
        mode = 1'b1; out_ready = 4'hF;
        for (int i = 0; i <= 3; i++) begin
            in_valid = 1'b1;
            if (i < 3) begin
                in_dest = t3_dest[i];
                in_data = t3_data[i];
            end else begin
                mode    = 1'b0;
                in_data = 8'hB0;
            end
            sample();
            if (i > 0) begin
                check("t3_out_valid", 32'(out_valid), 32'd1 << t3_dest[i-1]);
                check("t3_out_data", 32'(out_data), 32'(t3_data[i-1]));
            end
            tick();
        end
        in_valid = 1'b0;
        sample();
        check("t3_rr_unchanged", 32'(out_valid), 32'h1);
        check("t3_rr_data", 32'(out_data), 32'hB0);
        tick();

        // Backpressure on channel 1 holds 0x22 and stalls the input.
        do_reset();
        mode = 1'b0; out_ready = 4'b1101;
        in_valid = 1'b1; in_data = 8'h21;
        sample();
        tick();
        in_data = 8'h22;
        sample();
        check("t2_first_ch0", 32'(out_valid), 32'h1);
        tick();
        in_data = 8'h23;
        for (int k = 0; k < 3; k++) begin
            sample();
            check("t2_stall_ready", 32'(in_ready), 32'd0);
            check("t2_hold_valid", 32'(out_valid), 32'h2);
            check("t2_hold_data", 32'(out_data), 32'h22);
            tick();
        end
        out_ready = 4'hF;
        sample();
        check("t2_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        sample();
        check("t2_next_ch2", 32'(out_valid), 32'h4);
        check("t2_next_data", 32'(out_data), 32'h23);
        tick();
        sample();
        check("t2_sent_cnt", 32'(sent_cnt), 32'd3);
        tick();

        // Reset while 0x77 is held on channel 2: it must vanish uncounted.
        do_reset();
        out_ready = 4'b1011;
        in_valid = 1'b1; in_data = 8'h75;
        sample(); tick();
        in_data = 8'h76;
        sample(); tick();
        in_data = 8'h77;
        sample(); tick();
        in_valid = 1'b0;
        sample();
        check("t5_held_valid", 32'(out_valid), 32'h4);
        check("t5_held_data", 32'(out_data), 32'h77);
        check("t5_held_ready", 32'(in_ready), 32'd0);
        tick();
        do_reset();
        out_ready = 4'hF;
        for (int k = 0; k < 3; k++) begin
            sample();
            check("t5_discarded", 32'(out_valid), 32'd0);
            tick();
        end

        // Counter wrap: 65535 deliveries reach 0xFFFF, one more wraps to 0.
        mode = 1'b0; out_ready = 4'hF; in_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        sample();
        check("t6_cnt_max", 32'(sent_cnt), 32'hFFFF);
        tick();
        in_valid = 1'b1; in_data = 8'hC3;
        tick();
        in_valid = 1'b0;
        tick();
        sample();
        check("t6_cnt_wrap", 32'(sent_cnt), 32'd0);
        tick();

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
